// File: rtl/mem_stall_ctrl.sv
// Data-memory access sequencer: req/ack handshake, pipeline stall and load-data hold.
// Optional stall-cycle counter output enabled by defining MEM_PERF_CNT_EN.
module mem_stall_ctrl #(
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned TIMEOUT = 255,
   parameter int unsigned CNT_W   = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              MemRead_i,
   input  logic              MemWrite_i,
   input  logic [ADDR_W-1:0] ALUResult_i,
   input  logic [DATA_W-1:0] MemWrData_i,
   output logic              mem_req_o,
   output logic              mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [DATA_W-1:0] mem_wdata_o,
   input  logic              mem_ack_i,
   input  logic [DATA_W-1:0] mem_rdata_i,
   output logic              stall_o,
   output logic [DATA_W-1:0] rdata_o,
   output logic              rdata_valid_o,
   output logic              timeout_o
`ifdef MEM_PERF_CNT_EN
   ,
   output logic [CNT_W-1:0]  stall_cycles_o
`endif
);

   typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

   localparam logic [CNT_W-1:0] WaitLast = CNT_W'(TIMEOUT - 1);

   state_e              state_q, state_d;
   logic [CNT_W-1:0]    wait_q, wait_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [DATA_W-1:0]   rdata_q, rdata_d;
   logic                we_q, we_d;
   logic                timeout_q, timeout_d;

   logic access, ack_hit, to_hit;

   assign access  = MemRead_i | MemWrite_i;
   assign ack_hit = (state_q == StBusy) && mem_ack_i;
   // Ack on the final wait cycle takes priority over the abort.
   assign to_hit  = (state_q == StBusy) && !mem_ack_i && (wait_q == WaitLast);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         wait_q    <= '0;
         addr_q    <= '0;
         wdata_q   <= '0;
         rdata_q   <= '0;
         we_q      <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         wait_q    <= wait_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         rdata_q   <= rdata_d;
         we_q      <= we_d;
         timeout_q <= timeout_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (access) state_d = StBusy;
         StBusy:  if (ack_hit || to_hit) state_d = StDone;
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      wait_d    = wait_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      rdata_d   = rdata_q;
      we_d      = we_q;
      timeout_d = timeout_q;
      if (state_q == StIdle && access) begin
         addr_d  = ALUResult_i;
         wdata_d = MemWrData_i;
         we_d    = MemWrite_i;
         wait_d  = '0;
      end
      if (state_q == StBusy) begin
         wait_d = wait_q + 1'b1;
      end
      if (ack_hit && !we_q) begin
         rdata_d = mem_rdata_i;
      end
      if (to_hit) begin
         timeout_d = 1'b1;
         if (!we_q) rdata_d = '0;
      end
   end

   always_comb begin
      mem_req_o     = 1'b0;
      stall_o       = 1'b0;
      rdata_valid_o = 1'b0;
      unique case (state_q)
         // Reset gating keeps stall low while reset is held, even with a request pending.
         StIdle:  stall_o = rst_n & access;
         StBusy: begin
            mem_req_o = 1'b1;
            stall_o   = 1'b1;
         end
         StDone:  rdata_valid_o = !we_q;
         default: ;
      endcase
   end

   assign mem_we_o    = we_q;
   assign mem_addr_o  = addr_q;
   assign mem_wdata_o = wdata_q;
   assign rdata_o     = rdata_q;
   assign timeout_o   = timeout_q;

`ifdef MEM_PERF_CNT_EN
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (stall_o && (stall_cnt_q != {CNT_W{1'b1}})) stall_cnt_d = stall_cnt_q + 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) stall_cnt_q <= '0;
      else        stall_cnt_q <= stall_cnt_d;
   end

   assign stall_cycles_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_mem_stall_ctrl.sv
// Self-checking bench for mem_stall_ctrl: directed cases plus randomized transactions
// checked against a transaction-level model (TIMEOUT set to 8).
module tb_mem_stall_ctrl;

   localparam int unsigned TO = 8;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        MemRead_i, MemWrite_i;
   logic [31:0] ALUResult_i, MemWrData_i;
   logic        mem_req_o, mem_we_o;
   logic [31:0] mem_addr_o, mem_wdata_o;
   logic        mem_ack_i;
   logic [31:0] mem_rdata_i;
   logic        stall_o;
   logic [31:0] rdata_o;
   logic        rdata_valid_o, timeout_o;
`ifdef MEM_PERF_CNT_EN
   logic [15:0] stall_cycles_o;
`endif

   int checks = 0;
   int failures = 0;

   // Transaction-level expectations
   logic [31:0] exp_rdata;
   logic        exp_to;
   int          exp_stall;

   mem_stall_ctrl #(
      .ADDR_W (32),
      .DATA_W (32),
      .TIMEOUT(TO),
      .CNT_W  (16)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .MemRead_i    (MemRead_i),
      .MemWrite_i   (MemWrite_i),
      .ALUResult_i  (ALUResult_i),
      .MemWrData_i  (MemWrData_i),
      .mem_req_o    (mem_req_o),
      .mem_we_o     (mem_we_o),
      .mem_addr_o   (mem_addr_o),
      .mem_wdata_o  (mem_wdata_o),
      .mem_ack_i    (mem_ack_i),
      .mem_rdata_i  (mem_rdata_i),
      .stall_o      (stall_o),
      .rdata_o      (rdata_o),
      .rdata_valid_o(rdata_valid_o),
      .timeout_o    (timeout_o)
`ifdef MEM_PERF_CNT_EN
      ,
      .stall_cycles_o(stall_cycles_o)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic idle_cycle();
      @(negedge clk);
      MemRead_i  = 1'b0;
      MemWrite_i = 1'b0;
      mem_ack_i  = 1'b0;
      #1;
      check("idle_stall", {31'b0, stall_o}, 0);
      check("idle_req", {31'b0, mem_req_o}, 0);
      check("idle_valid", {31'b0, rdata_valid_o}, 0);
   endtask

   // One full access; waits >= TO means the memory never acks.
   task automatic run_txn(input bit rd, input bit wr, input logic [31:0] addr,
                          input logic [31:0] data, input int waits, input logic [31:0] rval);
      bit is_rd;
      int k;
      is_rd = rd && !wr;
      @(negedge clk);
      mem_ack_i = 1'b0;
      check("idle_req_pre", {31'b0, mem_req_o}, 0);
      check("idle_valid_pre", {31'b0, rdata_valid_o}, 0);
      check("idle_rdata_held", rdata_o, exp_rdata);
      MemRead_i   = rd;
      MemWrite_i  = wr;
      ALUResult_i = addr;
      MemWrData_i = data;
      #1;
      check("idle_stall_comb", {31'b0, stall_o}, 1);
      k = 0;
      while (1) begin
         @(negedge clk);
         MemRead_i   = 1'($urandom);
         MemWrite_i  = 1'($urandom);
         ALUResult_i = $urandom;
         MemWrData_i = $urandom;
         mem_ack_i   = (k == waits);
         mem_rdata_i = (k == waits) ? rval : $urandom;
         #1;
         check("busy_req", {31'b0, mem_req_o}, 1);
         check("busy_stall", {31'b0, stall_o}, 1);
         check("busy_we", {31'b0, mem_we_o}, {31'b0, wr});
         check("busy_addr", mem_addr_o, addr);
         check("busy_wdata", mem_wdata_o, data);
         if (k == waits || k == int'(TO) - 1) break;
         k++;
      end
      if (waits >= int'(TO)) begin
         exp_to = 1'b1;
         if (is_rd) exp_rdata = 32'h0;
         exp_stall += int'(TO) + 1;
      end else begin
         if (is_rd) exp_rdata = rval;
         exp_stall += waits + 2;
      end
      @(negedge clk);
      MemRead_i   = 1'b0;
      MemWrite_i  = 1'b0;
      mem_ack_i   = 1'($urandom);
      mem_rdata_i = $urandom;
      #1;
      check("done_stall", {31'b0, stall_o}, 0);
      check("done_req", {31'b0, mem_req_o}, 0);
      check("done_valid", {31'b0, rdata_valid_o}, {31'b0, is_rd});
      check("done_rdata", rdata_o, exp_rdata);
      check("done_timeout", {31'b0, timeout_o}, {31'b0, exp_to});
`ifdef MEM_PERF_CNT_EN
      check("perf_cnt", {16'b0, stall_cycles_o}, exp_stall);
`endif
   endtask

   initial begin
      rst_n       = 1'b0;
      MemRead_i   = 1'b0;
      MemWrite_i  = 1'b0;
      ALUResult_i = '0;
      MemWrData_i = '0;
      mem_ack_i   = 1'b0;
      mem_rdata_i = '0;
      exp_rdata   = '0;
      exp_to      = 1'b0;
      exp_stall   = 0;
      repeat (2) @(negedge clk);
      check("rst_req", {31'b0, mem_req_o}, 0);
      check("rst_stall", {31'b0, stall_o}, 0);
      check("rst_rdata", rdata_o, 0);
      check("rst_addr", mem_addr_o, 0);
      check("rst_timeout", {31'b0, timeout_o}, 0);
      rst_n = 1'b1;
      idle_cycle();

      // Load with zero waits, then store with three waits
      run_txn(1'b1, 1'b0, 32'h10, 32'h0, 0, 32'hDEADBEEF);
      run_txn(1'b0, 1'b1, 32'h20, 32'h1234, 3, 32'h0);
`ifdef MEM_PERF_CNT_EN
      check("perf_t12", {16'b0, stall_cycles_o}, 7);
`endif
      // Back-to-back loads
      run_txn(1'b1, 1'b0, 32'h30, 32'h0, 1, 32'hA5A5_0001);
      run_txn(1'b1, 1'b0, 32'h34, 32'h0, 2, 32'h5A5A_0002);
      // Read and write together: write wins
      run_txn(1'b1, 1'b1, 32'h38, 32'hCAFE, 0, 32'hFFFF_FFFF);
      // Ack on the last allowed cycle, then a real timeout
      run_txn(1'b1, 1'b0, 32'h40, 32'h0, int'(TO) - 1, 32'h1111_2222);
      run_txn(1'b1, 1'b0, 32'h44, 32'h0, 50, 32'h0);
      idle_cycle();
      check("timeout_sticky", {31'b0, timeout_o}, 1);

      // Reset in the middle of a busy access
      @(negedge clk);
      MemRead_i   = 1'b1;
      ALUResult_i = 32'h50;
      @(negedge clk);
      #1;
      check("pre_rst_req", {31'b0, mem_req_o}, 1);
      rst_n = 1'b0;
      #1;
      check("async_rst_req", {31'b0, mem_req_o}, 0);
      check("async_rst_stall", {31'b0, stall_o}, 0);
      check("async_rst_timeout", {31'b0, timeout_o}, 0);
      check("async_rst_rdata", rdata_o, 0);
      @(negedge clk);
      MemRead_i = 1'b0;
      rst_n     = 1'b1;
      exp_rdata = '0;
      exp_to    = 1'b0;
      exp_stall = 0;
      idle_cycle();
      run_txn(1'b1, 1'b0, 32'h60, 32'h0, 0, 32'h600D_F00D);

      // Randomized transactions
      for (int n = 0; n < 40; n++) begin
         bit rd, wr;
         int gaps;
         rd = 1'($urandom);
         wr = 1'($urandom);
         if (!rd && !wr) rd = 1'b1;
         gaps = int'($urandom_range(0, 2));
         for (int g = 0; g < gaps; g++) idle_cycle();
         run_txn(rd, wr, $urandom, $urandom, int'($urandom_range(0, TO + 1)), $urandom);
      end
      idle_cycle();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
